// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory fetch channel.
// The fetch stage (master) holds req with a stable addr until ack; the
// memory (slave) returns rdata together with ack, possibly in the same cycle.
interface ifetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch.sv
// ifetch: program counter, instruction fetch and IF/ID pipeline register.
// A one-entry hold buffer absorbs a decode stall that lands on a fetch
// response; MEM-stage redirects retarget the PC.
// Build option IFETCH_FLUSH_EN: a redirect also squashes IF/ID, the hold
// buffer and any in-flight response (the latter via the DROP state).
// Without it, everything already fetched is delivered and only the fetch
// stream is retargeted.
//
// state | meaning
// FETCH | request outstanding at faddr
// HOLD  | response parked in hbuf while decode stalls, no request
// DROP  | wrong-path request still outstanding, its data is discarded
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_stall,
    input  logic            MEM_pcsrc,
    input  logic [31:0]     MEM_target,
    ifetch_if.master        imem,
    output logic [31:0]     ID_ir,
    output logic [31:0]     ID_npc
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] faddr, faddr_nxt;
    logic [31:0] hbuf_ir, hbuf_ir_nxt;
    logic [31:0] hbuf_npc, hbuf_npc_nxt;
    logic [31:0] ir_nxt, npc_nxt;
    logic [31:0] faddr_inc, seq_addr, target;
    logic        got;

    assign imem.req  = (state != HOLD) && !rst;
    assign imem.addr = faddr;

    // No request is issued in HOLD, so a stray ack there is ignored.
    assign got       = imem.ack && (state != HOLD);
    assign faddr_inc = faddr + 32'd4;
    assign target    = MEM_target & 32'hFFFF_FFFC;

`ifdef IFETCH_FLUSH_EN
    assign seq_addr = faddr_inc;
`else
    // pend marks a redirect that arrived while a fetch was in flight: the
    // response is still delivered, then fetching resumes at the saved pc.
    logic pend, pend_nxt;
    assign seq_addr = pend ? pc : faddr_inc;
`endif

    // Next-state, fetch-address and IF/ID update; redirect overrides last.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        faddr_nxt    = faddr;
        hbuf_ir_nxt  = hbuf_ir;
        hbuf_npc_nxt = hbuf_npc;
        ir_nxt       = ID_ir;
        npc_nxt      = ID_npc;
`ifndef IFETCH_FLUSH_EN
        pend_nxt     = pend;
`endif
        case (state)
            FETCH: begin
                if (got) begin
                    faddr_nxt = seq_addr;
                    pc_nxt    = seq_addr;
`ifndef IFETCH_FLUSH_EN
                    pend_nxt  = 1'b0;
`endif
                    if (ID_stall) begin
                        hbuf_ir_nxt  = imem.rdata;
                        hbuf_npc_nxt = faddr_inc;
                        state_nxt    = HOLD;
                    end else begin
                        ir_nxt  = imem.rdata;
                        npc_nxt = faddr_inc;
                    end
                end else if (!ID_stall) begin
                    ir_nxt = NOP_INSN;
                end
            end
            HOLD: begin
                if (!ID_stall) begin
                    ir_nxt    = hbuf_ir;
                    npc_nxt   = hbuf_npc;
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                if (got) begin
                    faddr_nxt = pc;
                    state_nxt = FETCH;
                end
                if (!ID_stall) begin
                    ir_nxt = NOP_INSN;
                end
            end
            default: state_nxt = FETCH;
        endcase

        if (MEM_pcsrc) begin
            pc_nxt = target;
`ifdef IFETCH_FLUSH_EN
            // Squash wins over a stall; ID_npc keeps its value under the bubble.
            ir_nxt  = NOP_INSN;
            npc_nxt = ID_npc;
            if (state == HOLD || got) begin
                faddr_nxt = target;
                state_nxt = FETCH;
            end else begin
                state_nxt = DROP;
            end
`else
            if (state == HOLD || got) begin
                faddr_nxt = target;
                pend_nxt  = 1'b0;
            end else begin
                pend_nxt  = 1'b1;
            end
`endif
        end
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            faddr    <= RESET_PC;
            hbuf_ir  <= NOP_INSN;
            hbuf_npc <= 32'h0;
            ID_ir    <= NOP_INSN;
            ID_npc   <= 32'h0;
`ifndef IFETCH_FLUSH_EN
            pend     <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            faddr    <= faddr_nxt;
            hbuf_ir  <= hbuf_ir_nxt;
            hbuf_npc <= hbuf_npc_nxt;
            ID_ir    <= ir_nxt;
            ID_npc   <= npc_nxt;
`ifndef IFETCH_FLUSH_EN
            pend     <= pend_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized bench for ifetch against a behavioural model.
// Memory returns the address as data with a selectable wait count.
// A second instance with RESET_PC = FFFF_FFF8 and zero-wait memory checks
// address wrap-around after reset.
module tb_ifetch;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk, rst;
    logic        ID_stall, MEM_pcsrc;
    logic [31:0] MEM_target;
    logic [31:0] ID_ir, ID_npc, w_ir, w_npc;

    int n_cmp, n_bad;
    int mode;           // 0: zero wait, 1: two waits, 2: random 0..3 waits
    int wcnt, wait_n;

    // behavioural model state
    logic [31:0] m_fa, m_after, m_ir, m_npc, m_hir, m_hnpc;
    logic        m_buf, m_disc, m_redir;

    ifetch_if mif ();
    ifetch_if wif ();

    ifetch dut (
        .clk        (clk),
        .rst        (rst),
        .ID_stall   (ID_stall),
        .MEM_pcsrc  (MEM_pcsrc),
        .MEM_target (MEM_target),
        .imem       (mif),
        .ID_ir      (ID_ir),
        .ID_npc     (ID_npc)
    );

    ifetch #(.RESET_PC(WRAP_PC)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .ID_stall   (1'b0),
        .MEM_pcsrc  (1'b0),
        .MEM_target (32'h0),
        .imem       (wif),
        .ID_ir      (w_ir),
        .ID_npc     (w_npc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input int m);
        if (m == 0) return 0;
        if (m == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    assign mif.ack   = mif.req && (wcnt == wait_n);
    assign mif.rdata = mif.addr;
    assign wif.ack   = wif.req;
    assign wif.rdata = wif.addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= 0;
            wait_n <= pick(mode);
        end else if (mif.req && mif.ack) begin
            wcnt   <= 0;
            wait_n <= pick(mode);
        end else if (mif.req) begin
            wcnt   <= wcnt + 1;
        end else begin
            wcnt   <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fa    = 32'h0;
        m_after = 32'h0;
        m_ir    = NOP_INSN;
        m_npc   = 32'h0;
        m_hir   = 32'h0;
        m_hnpc  = 32'h0;
        m_buf   = 1'b0;
        m_disc  = 1'b0;
        m_redir = 1'b0;
    endtask

    // One clock of the fetch rules: what is delivered, buffered or dropped.
    task automatic model_step();
        logic        got, was_buf, do_norm;
        logic [31:0] t;
        was_buf = m_buf;
        got     = !m_buf && (wcnt == wait_n);
        t       = MEM_target & 32'hFFFF_FFFC;
        do_norm = 1'b1;
`ifdef IFETCH_FLUSH_EN
        if (MEM_pcsrc) begin
            do_norm = 1'b0;
            m_ir    = NOP_INSN;
            if (was_buf || got) begin
                m_fa   = t;
                m_buf  = 1'b0;
                m_disc = 1'b0;
            end else begin
                m_disc  = 1'b1;
                m_after = t;
            end
        end
`endif
        if (do_norm) begin
            if (m_buf) begin
                if (!ID_stall) begin
                    m_ir  = m_hir;
                    m_npc = m_hnpc;
                    m_buf = 1'b0;
                end
            end else if (got && m_disc) begin
                m_disc = 1'b0;
                m_fa   = m_after;
                if (!ID_stall) m_ir = NOP_INSN;
            end else if (got) begin
                if (!ID_stall) begin
                    m_ir  = m_fa;
                    m_npc = m_fa + 32'd4;
                end else begin
                    m_hir  = m_fa;
                    m_hnpc = m_fa + 32'd4;
                    m_buf  = 1'b1;
                end
                m_fa    = m_redir ? m_after : m_fa + 32'd4;
                m_redir = 1'b0;
            end else if (!ID_stall) begin
                m_ir = NOP_INSN;
            end
        end
`ifndef IFETCH_FLUSH_EN
        if (MEM_pcsrc) begin
            if (was_buf || got) begin
                m_fa    = t;
                m_redir = 1'b0;
            end else begin
                m_redir = 1'b1;
                m_after = t;
            end
        end
`endif
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin : cmp
        forever begin
            @(negedge clk);
            chk("id_ir", ID_ir, m_ir);
            chk("id_npc", ID_npc, m_npc);
            chk("imem_req", {31'b0, mif.req}, {31'b0, !rst && !m_buf});
            if (mif.req) chk("imem_addr", mif.addr, m_fa);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_checks();
        chk("rst_ir", ID_ir, NOP_INSN);
        chk("rst_npc", ID_npc, 32'h0);
        chk("rst_req", {31'b0, mif.req}, 32'd0);
        chk("rst_w_ir", w_ir, NOP_INSN);
        chk("rst_w_npc", w_npc, 32'h0);
        chk("rst_w_req", {31'b0, wif.req}, 32'd0);
    endtask

    // Called right after rst falls; with_main adds zero-wait stream checks.
    task automatic wrap_checks(input bit with_main);
        chk("rel_req", {31'b0, mif.req}, 32'd1);
        chk("rel_addr", mif.addr, 32'h0);
        chk("w_rel_req", {31'b0, wif.req}, 32'd1);
        chk("w_addr0", wif.addr, 32'hFFFF_FFF8);
        step();
        chk("w_ir0", w_ir, 32'hFFFF_FFF8);
        chk("w_npc0", w_npc, 32'hFFFF_FFFC);
        chk("w_addr1", wif.addr, 32'hFFFF_FFFC);
        if (with_main) begin
            chk("zw_ir0", ID_ir, 32'h0);
            chk("zw_npc0", ID_npc, 32'h4);
        end
        step();
        chk("w_ir1", w_ir, 32'hFFFF_FFFC);
        chk("w_npc1", w_npc, 32'h0);
        chk("w_addr2", wif.addr, 32'h0);
        if (with_main) begin
            chk("zw_ir1", ID_ir, 32'h4);
            chk("zw_npc1", ID_npc, 32'h8);
        end
        step();
        chk("w_ir2", w_ir, 32'h0);
        chk("w_npc2", w_npc, 32'h4);
        if (with_main) begin
            chk("zw_ir2", ID_ir, 32'h8);
            chk("zw_npc2", ID_npc, 32'hC);
        end
    endtask

    initial begin : stim
        logic [31:0] x;
        bit          found;
        n_cmp      = 0;
        n_bad      = 0;
        mode       = 0;
        rst        = 1'b0;
        ID_stall   = 1'b0;
        MEM_pcsrc  = 1'b0;
        MEM_target = 32'h0;
        #1 rst = 1'b1;
        step();
        step();
        reset_checks();
        rst = 1'b0;
        #1;
        wrap_checks(1'b1);
        repeat (4) step();

        // two wait states
        mode = 1;
        repeat (12) step();
        mode = 0;
        repeat (6) step();

        // three-cycle stall landing on an ack cycle
        ID_stall = 1'b1;
        x = m_fa;
        step();
        chk("hold_req", {31'b0, mif.req}, 32'd0);
        chk("hold_ir", ID_ir, x - 32'd4);
        step();
        chk("hold_req2", {31'b0, mif.req}, 32'd0);
        chk("hold_ir2", ID_ir, x - 32'd4);
        step();
        ID_stall = 1'b0;
        step();
        chk("rel_buf_ir", ID_ir, x);
        chk("rel_buf_npc", ID_npc, x + 32'd4);
        chk("rel_next_req", {31'b0, mif.req}, 32'd1);
        chk("rel_next_addr", mif.addr, x + 32'd4);
        step();
        chk("rel_after_ir", ID_ir, x + 32'd4);

        // redirect during an outstanding two-wait fetch at 0x20
        mode       = 1;
        MEM_pcsrc  = 1'b1;
        MEM_target = 32'h20;
        step();
        MEM_pcsrc  = 1'b0;
        chk("rd_addr20", mif.addr, 32'h20);
        chk("rd_req20", {31'b0, mif.req}, 32'd1);
        MEM_pcsrc  = 1'b1;
        MEM_target = 32'h100;
        step();
        MEM_pcsrc  = 1'b0;
        chk("rd_edge_ir", ID_ir, NOP_INSN);
        chk("rd_hold_addr", mif.addr, 32'h20);
        step();
        chk("rd_hold_addr2", mif.addr, 32'h20);
        step();
        chk("rd_next_addr", mif.addr, 32'h100);
        chk("rd_next_req", {31'b0, mif.req}, 32'd1);
`ifdef IFETCH_FLUSH_EN
        chk("rd_drop_ir", ID_ir, NOP_INSN);
`else
        chk("rd_deliv_ir", ID_ir, 32'h20);
        chk("rd_deliv_npc", ID_npc, 32'h24);
`endif
        repeat (6) step();

        // random traffic
        mode = 2;
        for (int i = 0; i < 400; i++) begin
            ID_stall  = ($urandom_range(0, 3) == 0);
            MEM_pcsrc = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       MEM_target = $urandom_range(0, 32'h3FF);
                1:       MEM_target = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: MEM_target = $urandom;
            endcase
            step();
        end
        ID_stall  = 1'b0;
        MEM_pcsrc = 1'b0;

        // reset pulse in the middle of a wait
        mode  = 1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (mif.req && wcnt == 1) found = 1'b1;
        end
        chk("reach_wait", {31'b0, found}, 32'd1);
        rst = 1'b1;
        #1;
        reset_checks();
        #1 rst = 1'b0;
        #1;
        wrap_checks(1'b0);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage with integrated IF/ID pipeline register. Holds the program counter, fetches one instruction per cycle from a wait-state-capable instruction memory and presents `ID_ir`/`ID_npc` to the decode stage. It also absorbs decode stalls through a one-entry hold buffer and applies branch/jump redirects from the MEM stage.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INSN`, 32'h0000_0000: bubble instruction (`sll $0,$0,0`) loaded into IF/ID.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ID_stall` in 1: hazard unit; hold IF/ID and PC.
- `MEM_pcsrc` in 1: redirect request (taken branch/jump).
- `MEM_target` in 32: redirect target PC.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `ID_ir` out 32: IF/ID instruction register.
- `ID_npc` out 32: IF/ID next PC (fetch address + 4).

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `faddr`: in-flight fetch address.
  - `hbuf_ir`/`hbuf_npc`: hold buffer.
  - `state`: one of FETCH, HOLD, DROP.
- `imem_addr` = `faddr`. `imem_req` = (`state` != HOLD) and !`rst`. The request is held asserted with stable `imem_addr` until `imem_ack`.
- FETCH:
  - If `imem_ack` and !`ID_stall`: `ID_ir` <= `imem_rdata`, `ID_npc` <= `faddr`+4, `faddr` <= `pc` <= `faddr`+4. Stay in FETCH.
  - If `imem_ack` and `ID_stall`: capture into hbuf and advance `pc`/`faddr`. Go to HOLD.
  - If no ack and !`ID_stall`: IF/ID <= {`NOP_INSN`, `ID_npc` unchanged} (bubble).
  - If no ack and `ID_stall`: IF/ID holds.
- HOLD:
  - No request.
  - When `ID_stall` falls: IF/ID <= hbuf. Go to FETCH.
- DROP:
  - The request stays at the old `faddr`.
  - On `imem_ack`: discard data, `faddr` <= `pc` (the redirect target). Go to FETCH.
  - IF/ID receives bubbles while !`ID_stall`.
- Redirect (`MEM_pcsrc`=1) has priority over every other update:
  - `pc` <= `MEM_target`.
  - If no fetch is in flight, or the ack arrives this cycle: `faddr` <= `MEM_target`.
  - Otherwise see Configuration.
- PC arithmetic is mod 2^32; `faddr`+4 wraps from 32'hFFFF_FFFC to 0. Bits [1:0] of `MEM_target` are forced to 0.

## Timing
- Reset values:
  - `ID_ir` = `NOP_INSN`, `ID_npc` = 0.
  - `pc` = `faddr` = `RESET_PC`, `state` = FETCH.
  - `imem_req` = 0 while `rst` is high.
- First request is issued in the first cycle after `rst` deasserts.
- Latency: the instruction is visible on `ID_ir` one cycle after the `imem_ack` edge.
- Zero-wait memory gives 1 instruction per cycle.
- Stall release from HOLD: the buffered instruction appears one cycle after `ID_stall` falls. The next request issues in that same cycle.
- Reset mid-fetch abandons the outstanding request. Memory must tolerate `imem_req` dropping without an ack.

## Configuration
- `IFETCH_FLUSH_EN` defined:
  - Redirect cycle loads IF/ID with {`NOP_INSN`, `ID_npc`}, even if `ID_stall`.
  - A same-cycle `imem_ack` is discarded.
  - HOLD content is discarded and the state goes to FETCH.
  - A redirect with a fetch in flight and no ack goes to DROP.
- Undefined:
  - No squash is applied. IF/ID, hbuf and an in-flight response are delivered normally.
  - After delivery, fetch resumes at `MEM_target`.
  - DROP is never entered. Wrong-path squashing belongs to the hazard unit.

## Test plan
- Reset, zero-wait memory returning `addr` as data:
  - Expect `ID_ir` = 0, 4, 8, … on consecutive cycles.
  - Expect `ID_npc` = `ID_ir`+4.
- Memory with 2 wait states:
  - Expect a bubble pattern of two `NOP_INSN` cycles per instruction.
  - Expect `imem_addr` stable while `imem_req` is held.
- `ID_stall` for 3 cycles, asserted on an ack cycle:
  - Expect `ID_ir` to hold and state to go to HOLD with `imem_req`=0.
  - On release, expect the buffered instruction next cycle, with no instruction lost or duplicated.
- Flush build, `MEM_pcsrc` with `MEM_target`=32'h100 during an outstanding 2-wait fetch at 32'h20:
  - Expect DROP and the 32'h20 data discarded.
  - Expect the next request at 32'h100 and `ID_ir` = NOP on the redirect edge.
- Non-flush build, same stimulus:
  - Expect the 32'h20 instruction delivered.
  - Expect the next request at 32'h100.
- Start at `RESET_PC`=32'hFFFF_FFF8:
  - Expect fetches at …FFF8, …FFFC, then 0.
  - Expect `rst` pulsed mid-wait to return all outputs to their reset values asynchronously.
